dm_req_arbiter: RTL and testbench

// - Shares the single-port data-memory SRAM between two requesters:
//   M0 = CPU load/store unit, M1 = DMA/debug port.
// - Arbitrates, latches one command, and issues a single one-cycle wen/ren

---
 rtl/dm_req_arbiter_pkg.sv | 26 ++
 rtl/dm_req_arbiter_rr_arb2.sv | 55 +++++
 rtl/dm_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dm_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_req_arbiter_pkg.sv
// dm_arb_pkg
// Shared definitions for the data-memory request arbiter:
//   - arb_state_t   : arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   - PRIO_RR/FIXED : values accepted by the PRIO_MODE parameter
//   - LAT_CNT_W     : width of the read-latency down-counter
//   - out_of_range(): address decode shared by the top level
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam int LAT_CNT_W = 8;

  // Any set bit above the decoded byte-address field means the access
  // falls outside the data memory.
  function automatic logic out_of_range(input logic [31:0] addr, input int aw);
    return (addr >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/dm_req_arbiter_rr_arb2.sv
// rr_arb2
// Two-way grant generator for the data-memory arbiter. Grants are purely
// combinational from the request lines; a last-grant pointer remembers who
// won the previous arbitration so that, in round-robin mode, a tie goes to
// the other requester.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   req0, req1     : requests from M0 (CPU) and M1 (DMA/debug)
//   update         : 1 when the grant is actually being consumed
//   gnt0, gnt1     : one-hot (or zero) grant
module rr_arb2
  import dm_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  // 1 = M1 received the most recent grant. Resets to 1 so M0 wins the
  // first tie after reset.
  logic last1;

  // On a tie, fixed-priority mode always picks M0; round-robin mode picks
  // whichever requester did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if ((PRIO_MODE == PRIO_FIXED) || last1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Pointer moves on every consumed grant, in either mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last1 <= 1'b1;
    end else if (update && (gnt0 || gnt1)) begin
      last1 <= gnt1;
    end
  end

endmodule

// File: rtl/dm_req_arbiter.sv
// dm_req_arbiter
// Shares the single-port data-memory SRAM between the CPU load/store unit
// (M0) and the DMA/debug port (M1). One command is latched per arbitration
// and issued as a single-cycle mem_wen or mem_ren strobe; the winner gets
// an ack pulse, and for reads an rvalid pulse carrying mem_rdata once the
// memory latency has elapsed. Out-of-range addresses never reach the
// memory: they are acked with err (and, for reads, rvalid with zero data).
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   mN_req/wen/be/addr/wdata/pc : requester N command (held until mN_ack)
//   mN_ack, mN_err            : acceptance pulse, out-of-range flag
//   mN_rvalid, mN_rdata       : read response (rdata valid with rvalid only)
//   mem_wen, mem_ren          : memory strobes, high for exactly one cycle
//   mem_BE/addr/wdata/PC      : latched command, held between accesses
//   mem_rdata                 : registered memory read data
module dm_req_arbiter
  import dm_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MEM_AW    = 12,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  output logic        m0_ack,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_pc,
  output logic        m1_ack,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_BE,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_PC,
  input  logic [31:0] mem_rdata
);

  arb_state_t state;

  logic gnt0, gnt1;

  // Latched command attributes needed after IDLE.
  logic win1;
  logic cmd_wen;
  logic cmd_oor;
  // 0 while an out-of-range read is being answered, so rdata reads as zero.
  logic rd_mem;
  logic [LAT_CNT_W-1:0] lat_cnt;

  // Winner's command, selected from the grant.
  logic        sel_wen;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_pc;
  logic        sel_oor;

  rr_arb2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (m0_req),
    .req1  (m1_req),
    .update(state == ST_IDLE),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    sel_wen   = gnt1 ? m1_wen   : m0_wen;
    sel_be    = gnt1 ? m1_be    : m0_be;
    sel_addr  = gnt1 ? m1_addr  : m0_addr;
    sel_wdata = gnt1 ? m1_wdata : m0_wdata;
    sel_pc    = gnt1 ? m1_pc    : m0_pc;
    sel_oor   = out_of_range(sel_addr, MEM_AW);
  end

  // Read data is taken straight from the memory in the rvalid cycle, since
  // the SRAM only presents it for that cycle; outside rvalid it is forced
  // to zero.
  assign m0_rdata = (m0_rvalid && rd_mem) ? mem_rdata : 32'd0;
  assign m1_rdata = (m1_rvalid && rd_mem) ? mem_rdata : 32'd0;

  // Arbiter FSM. All outputs are registered and set on the transition into
  // the cycle in which they are visible, so ack and the memory strobe appear
  // during ISSUE, and rvalid appears in the final WAIT cycle. Pulse outputs
  // default to 0 every cycle; the mem_* command bus holds its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      win1      <= 1'b0;
      cmd_wen   <= 1'b0;
      cmd_oor   <= 1'b0;
      rd_mem    <= 1'b0;
      lat_cnt   <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_BE    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_PC    <= 32'd0;
    end else begin
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            win1      <= gnt1;
            cmd_wen   <= sel_wen;
            cmd_oor   <= sel_oor;
            rd_mem    <= !sel_oor;
            mem_BE    <= sel_be;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_PC    <= sel_pc;
            m0_ack    <= gnt0;
            m1_ack    <= gnt1;
            m0_err    <= gnt0 && sel_oor;
            m1_err    <= gnt1 && sel_oor;
            if (sel_oor) begin
              // Rejected reads are answered in the ack cycle.
              m0_rvalid <= gnt0 && !sel_wen;
              m1_rvalid <= gnt1 && !sel_wen;
            end else begin
              mem_wen <= sel_wen;
              mem_ren <= !sel_wen;
            end
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!cmd_wen && !cmd_oor) begin
            lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
            if (RD_LAT == 1) begin
              m0_rvalid <= !win1;
              m1_rvalid <= win1;
            end
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end

        // lat_cnt counts the WAIT cycles still to come after the current
        // one; rvalid is raised on entry to the last of them.
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            if (lat_cnt == LAT_CNT_W'(1)) begin
              m0_rvalid <= !win1;
              m1_rvalid <= win1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_req_arbiter.sv
// tb_dm_req_arbiter
// Directed bench for dm_req_arbiter. Two instances share one set of
// requester inputs: u_rr (round-robin, RD_LAT=1) and u_fx (fixed priority,
// RD_LAT=2). Each has its own behavioural SRAM with the matching read
// latency. 'sel' chooses which instance the generic access task observes.
// Latencies are reported as the rising edge, counted from the request,
// at which the requester would sample the pulse.
module tb_dm_req_arbiter;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;

  logic        r_m0_ack, r_m0_rvalid, r_m0_err, r_m1_ack, r_m1_rvalid, r_m1_err;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic        r_mem_wen, r_mem_ren;
  logic [3:0]  r_mem_BE;
  logic [31:0] r_mem_addr, r_mem_wdata, r_mem_PC, r_mem_rdata;

  logic        f_m0_ack, f_m0_rvalid, f_m0_err, f_m1_ack, f_m1_rvalid, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_mem_wen, f_mem_ren;
  logic [3:0]  f_mem_BE;
  logic [31:0] f_mem_addr, f_mem_wdata, f_mem_PC, f_mem_rdata;

  dm_req_arbiter #(.PRIO_MODE(0), .MEM_AW(12), .RD_LAT(1)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_ack(r_m0_ack), .m0_rvalid(r_m0_rvalid),
    .m0_rdata(r_m0_rdata), .m0_err(r_m0_err),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_pc(m1_pc), .m1_ack(r_m1_ack), .m1_rvalid(r_m1_rvalid),
    .m1_rdata(r_m1_rdata), .m1_err(r_m1_err),
    .mem_wen(r_mem_wen), .mem_ren(r_mem_ren), .mem_BE(r_mem_BE), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_PC(r_mem_PC), .mem_rdata(r_mem_rdata)
  );

  dm_req_arbiter #(.PRIO_MODE(1), .MEM_AW(12), .RD_LAT(2)) u_fx (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_ack(f_m0_ack), .m0_rvalid(f_m0_rvalid),
    .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_pc(m1_pc), .m1_ack(f_m1_ack), .m1_rvalid(f_m1_rvalid),
    .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .mem_wen(f_mem_wen), .mem_ren(f_mem_ren), .mem_BE(f_mem_BE), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_PC(f_mem_PC), .mem_rdata(f_mem_rdata)
  );

  // Behavioural SRAMs: byte-enabled writes, registered reads with one
  // (u_rr) or two (u_fx) cycles of latency.
  logic [31:0] r_ram [0:1023];
  logic [31:0] f_ram [0:1023];
  logic [31:0] f_rd1;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      r_ram[i] = 32'd0;
      f_ram[i] = 32'd0;
    end
    r_mem_rdata = 32'd0;
    f_mem_rdata = 32'd0;
    f_rd1       = 32'd0;
  end

  always @(posedge clk) begin
    if (r_mem_wen)
      r_ram[r_mem_addr[11:2]] <= (r_ram[r_mem_addr[11:2]] & ~be_mask(r_mem_BE)) |
                                 (r_mem_wdata & be_mask(r_mem_BE));
    if (r_mem_ren) r_mem_rdata <= r_ram[r_mem_addr[11:2]];
    if (f_mem_wen)
      f_ram[f_mem_addr[11:2]] <= (f_ram[f_mem_addr[11:2]] & ~be_mask(f_mem_BE)) |
                                 (f_mem_wdata & be_mask(f_mem_BE));
    if (f_mem_ren) f_rd1 <= f_ram[f_mem_addr[11:2]];
    f_mem_rdata <= f_rd1;
  end

  // Observation mux for the generic access task.
  logic        sel;
  logic [1:0]  s_ack, s_rvalid, s_err;
  logic [31:0] s_rdata0, s_rdata1;
  logic        s_wen, s_ren;

  assign s_ack    = sel ? {f_m1_ack, f_m0_ack}       : {r_m1_ack, r_m0_ack};
  assign s_rvalid = sel ? {f_m1_rvalid, f_m0_rvalid} : {r_m1_rvalid, r_m0_rvalid};
  assign s_err    = sel ? {f_m1_err, f_m0_err}       : {r_m1_err, r_m0_err};
  assign s_rdata0 = sel ? f_m0_rdata : r_m0_rdata;
  assign s_rdata1 = sel ? f_m1_rdata : r_m1_rdata;
  assign s_wen    = sel ? f_mem_wen : r_mem_wen;
  assign s_ren    = sel ? f_mem_ren : r_mem_ren;

  int vectors;
  int miscompares;

  int          res_ack_edge, res_rv_edge, res_strobes;
  logic        res_err, res_rv;
  logic [31:0] res_rdata;

  function automatic logic [31:0] pc_of(input logic [31:0] addr);
    return 32'h0040_0000 + addr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive_master(input int m, input logic req, input logic wen,
                              input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_wen = wen; m0_be = be; m0_addr = addr; m0_wdata = wdata;
      m0_pc = pc_of(addr);
    end else begin
      m1_req = req; m1_wen = wen; m1_be = be; m1_addr = addr; m1_wdata = wdata;
      m1_pc = pc_of(addr);
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One access from requester m on the selected instance. Starts on an
  // idle negedge, holds req until ack, then (for an in-range read) waits
  // for rvalid. Results land in the res_* variables.
  task automatic applyStimulus(input int m, input logic wen, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int  edge_no;
    bit  acked;
    @(negedge clk);
    drive_master(m, 1'b1, wen, be, addr, wdata);
    res_ack_edge = 0; res_rv_edge = 0; res_strobes = 0;
    res_err = 1'b0; res_rv = 1'b0; res_rdata = 32'd0;
    acked = 1'b0;
    edge_no = 0;
    for (int k = 0; k < 16 && !acked; k++) begin
      @(negedge clk);
      edge_no++;
      res_strobes += int'(s_wen) + int'(s_ren);
      if (s_ack[m]) begin
        acked = 1'b1;
        res_ack_edge = edge_no + 1;
        res_err = s_err[m];
        if (s_rvalid[m]) begin
          res_rv = 1'b1;
          res_rv_edge = edge_no + 1;
          res_rdata = (m == 0) ? s_rdata0 : s_rdata1;
        end
        drop_req(m);
      end
    end
    if (!acked) begin
      drop_req(m);
      checkOutput("ack_timeout", 32'd0, 32'd1);
    end else if (!wen && !res_rv) begin
      for (int k = 0; k < 16 && !res_rv; k++) begin
        @(negedge clk);
        edge_no++;
        res_strobes += int'(s_wen) + int'(s_ren);
        if (s_rvalid[m]) begin
          res_rv = 1'b1;
          res_rv_edge = edge_no + 1;
          res_rdata = (m == 0) ? s_rdata0 : s_rdata1;
        end
      end
      if (!res_rv) checkOutput("rvalid_timeout", 32'd0, 32'd1);
    end
  endtask

  int   grants;
  logic seen;
  bit   acked6;

  initial begin
    vectors = 0;
    miscompares = 0;
    sel = 1'b0;
    drive_master(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_master(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state: every output of both instances is zero.
    @(negedge clk);
    checkOutput("reset_rr_flags", 32'({r_m0_ack, r_m0_rvalid, r_m0_err, r_m1_ack,
                r_m1_rvalid, r_m1_err, r_mem_wen, r_mem_ren}), 32'd0);
    checkOutput("reset_rr_bus", r_mem_addr | r_mem_wdata | r_mem_PC | 32'(r_mem_BE), 32'd0);
    checkOutput("reset_fx_flags", 32'({f_m0_ack, f_m0_rvalid, f_m0_err, f_m1_ack,
                f_m1_rvalid, f_m1_err, f_mem_wen, f_mem_ren}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single write then read-back on the round-robin instance.
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    checkOutput("wr_ack_edge", 32'(res_ack_edge), 32'd2);
    checkOutput("wr_strobes", 32'(res_strobes), 32'd1);
    checkOutput("wr_err", 32'(res_err), 32'd0);
    checkOutput("wr_mem_pc", r_mem_PC, pc_of(32'h10));
    checkOutput("wr_mem_be", 32'(r_mem_BE), 32'hF);
    @(negedge clk);
    checkOutput("wr_wen_one_cycle", 32'({r_mem_wen, r_m0_ack}), 32'd0);
    checkOutput("wr_addr_held", r_mem_addr, 32'h10);
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'd0);
    checkOutput("rd_ack_edge", 32'(res_ack_edge), 32'd2);
    checkOutput("rd_rv_edge", 32'(res_rv_edge), 32'd3);
    checkOutput("rd_data", res_rdata, 32'hDEADBEEF);

    // Byte lanes, including a be=0 write that must still strobe but change nothing.
    applyStimulus(0, 1'b1, 4'hF, 32'h40, 32'h11223344);
    applyStimulus(0, 1'b1, 4'b1000, 32'h40, 32'hAA000000);
    applyStimulus(1, 1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF);
    checkOutput("be0_strobes", 32'(res_strobes), 32'd1);
    applyStimulus(1, 1'b0, 4'h0, 32'h40, 32'd0);
    checkOutput("lane_data", res_rdata, 32'hAA223344);

    // Out-of-range read and write: answered without touching the memory.
    applyStimulus(1, 1'b0, 4'h0, 32'h0000_1000, 32'd0);
    checkOutput("oor_rd_ack_edge", 32'(res_ack_edge), 32'd2);
    checkOutput("oor_rd_err", 32'(res_err), 32'd1);
    checkOutput("oor_rd_rv_edge", 32'(res_rv_edge), 32'd2);
    checkOutput("oor_rd_data", res_rdata, 32'd0);
    checkOutput("oor_rd_strobes", 32'(res_strobes), 32'd0);
    applyStimulus(0, 1'b1, 4'hF, 32'hFFFF_0000, 32'h12345678);
    checkOutput("oor_wr_flags", 32'({res_err, res_rv}), 32'b10);
    checkOutput("oor_wr_strobes", 32'(res_strobes), 32'd0);

    // Round-robin contention: both reads held, grants alternate from M0.
    sel = 1'b0;
    reset_dut();
    drive_master(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    drive_master(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'd0);
    grants = 0;
    for (int k = 0; k < 80 && grants < 6; k++) begin
      @(negedge clk);
      if (r_m0_rvalid) checkOutput("rr_m0_rdata", r_m0_rdata, 32'hDEADBEEF);
      if (r_m1_rvalid) checkOutput("rr_m1_rdata", r_m1_rdata, 32'hAA223344);
      if (r_m0_ack || r_m1_ack) begin
        checkOutput($sformatf("rr_grant%0d", grants), 32'({r_m1_ack, r_m0_ack}),
                    (grants % 2 == 0) ? 32'd1 : 32'd2);
        grants++;
      end
    end
    checkOutput("rr_grant_count", 32'(grants), 32'd6);
    drop_req(0);
    drop_req(1);
    repeat (4) @(negedge clk);

    // Fixed priority: M0 wins while held; M1 goes only after M0 drops.
    sel = 1'b1;
    reset_dut();
    drive_master(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0);
    drive_master(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'd0);
    grants = 0;
    for (int k = 0; k < 80 && grants < 5; k++) begin
      @(negedge clk);
      if (f_m0_ack || f_m1_ack) begin
        if (grants < 4) begin
          checkOutput($sformatf("fx_grant%0d", grants), 32'({f_m1_ack, f_m0_ack}), 32'd1);
          if (grants == 3) drop_req(0);
        end else begin
          checkOutput("fx_after_drop", 32'({f_m1_ack, f_m0_ack}), 32'd2);
          drop_req(1);
        end
        grants++;
      end
    end
    checkOutput("fx_grant_count", 32'(grants), 32'd5);
    repeat (4) @(negedge clk);

    // Reset during WAIT on the RD_LAT=2 instance aborts the read.
    sel = 1'b1;
    reset_dut();
    @(negedge clk);
    drive_master(0, 1'b1, 1'b0, 4'h0, 32'h44, 32'd0);
    acked6 = 1'b0;
    for (int k = 0; k < 10 && !acked6; k++) begin
      @(negedge clk);
      if (f_m0_ack) acked6 = 1'b1;
    end
    checkOutput("rst_pre_ack", 32'(acked6), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    drop_req(0);
    #1;
    checkOutput("rst_flags_now", 32'({f_m0_ack, f_m0_rvalid, f_mem_ren, f_mem_wen}), 32'd0);
    checkOutput("rst_addr_now", f_mem_addr, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | f_m0_rvalid | f_m1_rvalid | f_m0_ack | f_m1_ack;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      seen = seen | f_m0_rvalid | f_m1_rvalid | f_m0_ack | f_m1_ack;
    end
    checkOutput("rst_no_response", 32'(seen), 32'd0);
    applyStimulus(1, 1'b1, 4'hF, 32'h80, 32'h5A5A1234);
    checkOutput("post_rst_wr_ack_edge", 32'(res_ack_edge), 32'd2);
    applyStimulus(1, 1'b0, 4'h0, 32'h80, 32'd0);
    checkOutput("post_rst_rd_ack_edge", 32'(res_ack_edge), 32'd2);
    checkOutput("post_rst_rd_rv_edge", 32'(res_rv_edge), 32'd4);
    checkOutput("post_rst_rd_data", res_rdata, 32'h5A5A1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
